echo_multi: RTL and testbench
=============================

ECHO_MULTI -- requirements
Module: echo_multi

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning sample width, signed two's complement.
REQ-002 SHALL have parameter DEPTH_LOG2, default 14, meaning log2 of delay-buffer depth in samples (minimum 3).
REQ-003 SHALL have port clk  input  1  sole clock, all logic rising-edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port sample_in  input  WIDTH  incoming signed sample.
REQ-006 SHALL have port in_ready  input  1  one-cycle strobe marking sample_in valid.
REQ-007 SHALL have port mode  input  2  00 bypass, 01 feed-forward echo, 10 feedback echo, 11 treated as bypass.
REQ-008 SHALL have port next_D  input  1  one-cycle strobe stepping delay setting.
REQ-009 SHALL have port next_H  input  1  one-cycle strobe stepping echo height (decay) setting.
REQ-010 SHALL have port out  output  WIDTH  processed signed sample, held between strobes.
REQ-011 SHALL have port out_ready  output  1  one-cycle strobe marking out valid.

Function
REQ-012 SHALL use FSM IDLE -> READ -> MIX -> WRITE -> IDLE; IDLE leaves only on in_ready; other states advance unconditionally.
REQ-013 SHALL latch sample_in and mode on the in_ready cycle; out_ready asserts exactly 3 cycles after in_ready (in the WRITE state) with out updated the same cycle.
REQ-014 SHALL ignore in_ready while FSM is not IDLE (sample dropped, no out_ready).
REQ-015 SHALL keep delay_sel (2 bits, 0..3); delay length L = (delay_sel+1) << (DEPTH_LOG2-2) samples; next_D increments delay_sel, wrapping 3 -> 0.
REQ-016 SHALL keep height_sel (2 bits, 0..3); decay shift S = height_sel+1; next_H increments, wrapping 3 -> 0.
REQ-017 SHALL apply next_D/next_H changes only in IDLE; strobes arriving while busy are held pending and applied on return to IDLE; strobes coinciding with in_ready in IDLE affect the following sample, not the current one.
REQ-018 SHALL read delayed sample d from address wr_ptr - L (modulo 2^DEPTH_LOG2) in READ.
REQ-019 SHALL treat d as zero while fill count (samples written since reset, saturating at 2^DEPTH_LOG2) is less than L.
REQ-020 SHALL compute y = sat(x + (d >>> S)) with arithmetic shift, sum at WIDTH+1 bits, saturate to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
REQ-021 SHALL output y = x in bypass; still write x to the buffer so switching mode produces immediate echo.
REQ-022 SHALL write x (feed-forward/bypass) or y (feedback) at wr_ptr in WRITE, then increment wr_ptr modulo 2^DEPTH_LOG2.

Reset
REQ-023 SHALL on reset low, asynchronously: FSM IDLE, out = 0, out_ready = 0, wr_ptr = 0, fill count = 0, delay_sel = 0, height_sel = 0, pending strobes cleared.
REQ-024 SHALL, on reset mid-operation, abandon the in-flight sample with no out_ready; buffer contents need not be cleared (REQ-019 masks them).

Structure
REQ-025 SHALL place mode encodings, FSM state encodings and the saturation width rule in shared package synth_pkg.
REQ-026 SHALL instantiate one sub-module echo_delay_ram: single-port synchronous RAM, 2^DEPTH_LOG2 x WIDTH, 1-cycle read latency, no reset.

Verification (WIDTH=16, DEPTH_LOG2=4, so L=4 at delay_sel 0, S=1 at height_sel 0)
REQ-027 SHALL check impulse, feed-forward: 0x4000 then zeros -> out 0x4000, 0,0,0, 0x2000 at sample 4, 0 at sample 8; out_ready 3 cycles after each in_ready.
REQ-028 SHALL check feedback: same impulse -> 0x2000 at sample 4, 0x1000 at sample 8, 0x0800 at sample 12.
REQ-029 SHALL check saturation: constant 0x7000 feed-forward -> samples 0-3 = 0x7000, sample 4 onward 0x7FFF; constant 0x9000 -> 0x8000 from sample 4.
REQ-030 SHALL check settings: one next_D and one next_H pulse, impulse 0x4000 -> echo 0x1000 at sample 8 (L=8, S=2); four next_D pulses return L to 4.
REQ-031 SHALL check busy/boundary: in_ready on consecutive cycles -> second dropped; next_D during MIX applied after; 20 samples through DEPTH 16 verifies pointer wrap with correct echo.
REQ-032 SHALL check reset: assert reset during MIX -> no out_ready, out = 0, next impulse echoes only per REQ-019 (no stale data).

Source files
------------

// File: rtl/synth_pkg.sv
// Shared encodings for the echo datapath: mode field, FSM states and the
// width rule used when summing two samples ahead of saturation.
package synth_pkg;

  typedef enum logic [1:0] {
    MODE_BYPASS     = 2'b00,
    MODE_FF         = 2'b01,
    MODE_FB         = 2'b10,
    MODE_BYPASS_ALT = 2'b11
  } mode_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_READ  = 2'b01,
    ST_MIX   = 2'b10,
    ST_WRITE = 2'b11
  } state_t;

  // One guard bit is enough to hold the sum of two same-width samples.
  localparam int SAT_GUARD_BITS = 1;

  function automatic int sat_sum_width(input int w);
    return w + SAT_GUARD_BITS;
  endfunction

endpackage

// File: rtl/echo_delay_ram.sv
// Single-port synchronous delay buffer: one access per cycle, registered
// read data (read-before-write on a write cycle), no reset on contents.
module echo_delay_ram #(
  parameter int WIDTH      = 16,
  parameter int DEPTH_LOG2 = 14
) (
  input  logic                  clk,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic                  we,
  input  logic [WIDTH-1:0]      wdata,
  output logic [WIDTH-1:0]      rdata
);

  logic [WIDTH-1:0] mem [2**DEPTH_LOG2];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/echo_multi.sv
// Multi-mode echo: each accepted sample takes one IDLE->READ->MIX->WRITE pass,
// mixing in a delayed tap scaled by an arithmetic right shift, with saturation.
module echo_multi
  import synth_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int DEPTH_LOG2 = 14
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sample_in,
  input  logic             in_ready,
  input  logic [1:0]       mode,
  input  logic             next_D,
  input  logic             next_H,
  output logic [WIDTH-1:0] out,
  output logic             out_ready
);

  localparam int AW    = DEPTH_LOG2;
  localparam int SUM_W = sat_sum_width(WIDTH);
  localparam logic [AW:0] FILL_MAX = {1'b1, {AW{1'b0}}};

  state_t                  state;
  logic [AW-1:0]           wr_ptr;
  logic [AW:0]             fill;
  logic [1:0]              delay_sel;
  logic [1:0]              height_sel;
  logic [1:0]              pend_d;
  logic [1:0]              pend_h;

  logic signed [WIDTH-1:0] x_p0;
  mode_t                   mode_p0;

  logic [AW:0]             dly_len;
  logic [2:0]              shamt;
  logic [AW-1:0]           ram_addr;
  logic                    ram_we;
  logic [WIDTH-1:0]        ram_wdata;
  logic [WIDTH-1:0]        ram_rdata;

  logic signed [WIDTH-1:0] d_p1;
  logic signed [WIDTH-1:0] dsh_p1;
  logic signed [SUM_W-1:0] sum_p1;
  logic signed [WIDTH-1:0] y_p1;

  function automatic logic signed [WIDTH-1:0] sat(input logic signed [SUM_W-1:0] s);
    if (s[SUM_W-1] != s[SUM_W-2]) begin
      sat = s[SUM_W-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end else begin
      sat = s[WIDTH-1:0];
    end
  endfunction

  always_comb begin
    dly_len = ((AW+1)'(delay_sel) + (AW+1)'(1)) << (AW-2);
    shamt   = {1'b0, height_sel} + 3'd1;
  end

  // Single port: the write address wins in WRITE, the delayed tap otherwise.
  always_comb begin
    ram_we    = (state == ST_WRITE);
    ram_addr  = ram_we ? wr_ptr : (wr_ptr - dly_len[AW-1:0]);
    ram_wdata = (mode_p0 == MODE_FB) ? out : x_p0;
  end

  echo_delay_ram #(
    .WIDTH      (WIDTH),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_ram (
    .clk   (clk),
    .addr  (ram_addr),
    .we    (ram_we),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // Stage p0: capture the accepted sample and its mode.
  always_ff @(posedge clk) begin
    if (state == ST_IDLE && in_ready) begin
      x_p0    <= sample_in;
      mode_p0 <= mode_t'(mode);
    end
  end

  // Stage p1: RAM data is valid in MIX; mask it until the buffer holds L samples.
  always_comb begin
    d_p1   = (fill < dly_len) ? '0 : ram_rdata;
    dsh_p1 = d_p1 >>> shamt;
    sum_p1 = {x_p0[WIDTH-1], x_p0} + {dsh_p1[WIDTH-1], dsh_p1};
    if (mode_p0 == MODE_FF || mode_p0 == MODE_FB) begin
      y_p1 = sat(sum_p1);
    end else begin
      y_p1 = x_p0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      out        <= '0;
      out_ready  <= 1'b0;
      wr_ptr     <= '0;
      fill       <= '0;
      delay_sel  <= 2'd0;
      height_sel <= 2'd0;
      pend_d     <= 2'd0;
      pend_h     <= 2'd0;
    end else begin
      out_ready <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (in_ready) begin
            // Settings strobes that coincide with a sample wait for the next one.
            state  <= ST_READ;
            pend_d <= pend_d + {1'b0, next_D};
            pend_h <= pend_h + {1'b0, next_H};
          end else begin
            delay_sel  <= delay_sel + {1'b0, next_D};
            height_sel <= height_sel + {1'b0, next_H};
          end
        end
        ST_READ: begin
          state  <= ST_MIX;
          pend_d <= pend_d + {1'b0, next_D};
          pend_h <= pend_h + {1'b0, next_H};
        end
        ST_MIX: begin
          state     <= ST_WRITE;
          out       <= y_p1;
          out_ready <= 1'b1;
          pend_d    <= pend_d + {1'b0, next_D};
          pend_h    <= pend_h + {1'b0, next_H};
        end
        ST_WRITE: begin
          state      <= ST_IDLE;
          wr_ptr     <= wr_ptr + 1'b1;
          if (fill != FILL_MAX) begin
            fill <= fill + 1'b1;
          end
          delay_sel  <= delay_sel + pend_d + {1'b0, next_D};
          height_sel <= height_sel + pend_h + {1'b0, next_H};
          pend_d     <= 2'd0;
          pend_h     <= 2'd0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_echo_multi.sv
// Directed bench for echo_multi (WIDTH=16, DEPTH_LOG2=4) with an output
// scoreboard fed by a small reference model of the echo buffer.
module tb_echo_multi;

  logic        clk;
  logic        reset;
  logic [15:0] sample_in;
  logic        in_ready;
  logic [1:0]  mode;
  logic        next_D;
  logic        next_H;
  logic [15:0] out;
  logic        out_ready;

  echo_multi #(.WIDTH(16), .DEPTH_LOG2(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .sample_in (sample_in),
    .in_ready  (in_ready),
    .mode      (mode),
    .next_D    (next_D),
    .next_H    (next_H),
    .out       (out),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] data;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;

  logic signed [15:0] mbuf [16];
  int mptr, mfill, mdsel, mhsel;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    mptr = 0; mfill = 0; mdsel = 0; mhsel = 0;
  endtask

  task automatic model_step(input logic signed [15:0] x, input logic [1:0] md,
                            output logic signed [15:0] y);
    int L, S, s;
    logic signed [15:0] d, dsh, ys;
    L = (mdsel + 1) * 4;
    S = mhsel + 1;
    d = (mfill < L) ? 16'sd0 : mbuf[(mptr - L) & 15];
    dsh = d >>> S;
    s = int'(x) + int'(dsh);
    if (s > 32767) ys = 16'sh7FFF;
    else if (s < -32768) ys = 16'sh8000;
    else ys = 16'(s);
    y = (md == 2'b01 || md == 2'b10) ? ys : x;
    mbuf[mptr] = (md == 2'b10) ? y : x;
    mptr = (mptr + 1) & 15;
    if (mfill < 16) mfill++;
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge where it is idle again.
  task automatic send(input logic [15:0] x, input logic [1:0] md, input bit use_exp,
                      input logic [15:0] exp_v, input bit with_h = 1'b0);
    logic signed [15:0] y;
    exp_t e;
    sample_in = x; mode = md; in_ready = 1'b1; next_H = with_h;
    model_step(x, md, y);
    if (with_h) mhsel = (mhsel + 1) % 4;
    e.data = use_exp ? exp_v : y;
    e.cyc  = cyc + 3;
    q.push_back(e);
    @(negedge clk);
    in_ready = 1'b0; next_H = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic pulse(input bit d, input bit h);
    next_D = d; next_H = h;
    if (d) mdsel = (mdsel + 1) % 4;
    if (h) mhsel = (mhsel + 1) % 4;
    @(negedge clk);
    next_D = 1'b0; next_H = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    logic [15:0] v;
    reset = 1'b0; sample_in = '0; in_ready = 1'b0; mode = 2'b00;
    next_D = 1'b0; next_H = 1'b0;
    for (int i = 0; i < 16; i++) mbuf[i] = '0;
    model_reset();

    fork
      forever begin
        @(posedge clk);
        #1;
        if (out_ready) begin
          if (q.size() == 0) begin
            check("unexpected_out_ready", {16'h0, out}, 32'hFFFF_FFFF);
          end else begin
            exp_t e;
            e = q.pop_front();
            check("out_data", {16'h0, out}, {16'h0, e.data});
            check("out_cycle", cyc, e.cyc);
          end
        end
      end
    join_none

    repeat (2) @(negedge clk);
    check("reset_out", {16'h0, out}, 32'h0);
    check("reset_out_ready", {31'h0, out_ready}, 32'h0);
    reset = 1'b1;
    @(negedge clk);

    // Feed-forward impulse
    send(16'h4000, 2'b01, 1'b1, 16'h4000);
    for (int i = 1; i <= 8; i++) send(16'h0, 2'b01, 1'b1, (i == 4) ? 16'h2000 : 16'h0);

    // Feedback impulse
    do_reset();
    send(16'h4000, 2'b10, 1'b1, 16'h4000);
    for (int i = 1; i <= 12; i++)
      send(16'h0, 2'b10, 1'b1, (i == 4) ? 16'h2000 : (i == 8) ? 16'h1000 : (i == 12) ? 16'h0800 : 16'h0);

    // Saturation both rails
    do_reset();
    for (int i = 0; i < 8; i++) send(16'h7000, 2'b01, 1'b1, (i < 4) ? 16'h7000 : 16'h7FFF);
    do_reset();
    for (int i = 0; i < 8; i++) send(16'h9000, 2'b01, 1'b1, (i < 4) ? 16'h9000 : 16'h8000);

    // Settings: L=8, S=2, then three more next_D wrap back to L=4
    do_reset();
    pulse(1'b1, 1'b1);
    send(16'h4000, 2'b01, 1'b1, 16'h4000);
    for (int i = 1; i <= 8; i++) send(16'h0, 2'b01, 1'b1, (i == 8) ? 16'h1000 : 16'h0);
    pulse(1'b1, 1'b0); pulse(1'b1, 1'b0); pulse(1'b1, 1'b0);
    send(16'h4000, 2'b01, 1'b1, 16'h4000);
    for (int i = 1; i <= 4; i++) send(16'h0, 2'b01, 1'b1, (i == 4) ? 16'h1000 : 16'h0);

    // Back-to-back in_ready: the second sample must be dropped
    do_reset();
    sample_in = 16'h4000; mode = 2'b01; in_ready = 1'b1;
    begin
      logic signed [15:0] y;
      exp_t e;
      model_step(16'h4000, 2'b01, y);
      e.data = 16'h4000; e.cyc = cyc + 3;
      q.push_back(e);
    end
    @(negedge clk);
    sample_in = 16'h1234;
    @(negedge clk);
    in_ready = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 1; i <= 4; i++) send(16'h0, 2'b01, 1'b1, (i == 4) ? 16'h2000 : 16'h0);

    // next_D strobe during MIX takes effect after the in-flight sample
    sample_in = 16'h0; mode = 2'b01; in_ready = 1'b1;
    begin
      logic signed [15:0] y;
      exp_t e;
      model_step(16'h0, 2'b01, y);
      e.data = y; e.cyc = cyc + 3;
      q.push_back(e);
    end
    @(negedge clk); in_ready = 1'b0;
    @(negedge clk); next_D = 1'b1;
    @(negedge clk); next_D = 1'b0; mdsel = (mdsel + 1) % 4;
    @(negedge clk);
    send(16'h4000, 2'b01, 1'b1, 16'h4000);
    for (int i = 1; i <= 8; i++) send(16'h0, 2'b01, 1'b0, 16'h0);

    // Pointer wrap with mixed data, plus next_H coinciding with in_ready
    do_reset();
    for (int i = 0; i < 20; i++) begin
      v = 16'($urandom_range(0, 65535));
      send(v, (i < 10) ? 2'b01 : 2'b10, 1'b0, 16'h0, (i == 10));
    end

    // Reset during MIX abandons the sample; stale buffer must stay masked
    sample_in = 16'h7000; mode = 2'b01; in_ready = 1'b1;
    @(negedge clk); in_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    #1;
    check("mid_reset_out", {16'h0, out}, 32'h0);
    check("mid_reset_out_ready", {31'h0, out_ready}, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    check("after_reset_out_ready", {31'h0, out_ready}, 32'h0);
    send(16'h1000, 2'b01, 1'b1, 16'h1000);
    for (int i = 1; i <= 4; i++) send(16'h0, 2'b01, 1'b1, (i == 4) ? 16'h0800 : 16'h0);

    repeat (8) @(negedge clk);
    check("queue_drained", q.size(), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
